// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// ALU operations, datapath mux selects, FSM states and instruction classes.
package mc_ctrl_pkg;

  localparam int CNT_W = 16;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_AND  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_SLL  = 4'd3,
    ALU_SLT  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SUB  = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_BEQ  = 4'd8,
    ALU_BNE  = 4'd9,
    ALU_NONE = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {PC_PLUS4, PC_BRANCH, PC_JUMP, PC_REG} pc_src_e;
  typedef enum logic [1:0] {WB_ALU_RES, WB_MEM_DATA, WB_PC, WB_LO} wb_sel_e;
  typedef enum logic [1:0] {SRCB_RT, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2} alu_src_b_e;
  typedef enum logic [1:0] {RD_RT, RD_RD, RD_R31} reg_dest_e;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD, S_MEM_WR,
    S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_JR, S_MULT, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_ILLEGAL, CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_J, CLS_JAL, CLS_JR, CLS_MULT, CLS_MFLO
  } instr_class_e;

endpackage

// File: rtl/mc_control_decode.sv
// Combinational instruction decoder: opcode/funct to class, ALU op and shift flag.
// MC_MULT_EN adds MULT/MULTU/MFLO; without it those functs decode as illegal.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_e cls,
  output logic [3:0]   alu_op,
  output logic         shift,
  output logic         illegal
);

  always_comb begin
    cls    = CLS_ILLEGAL;
    alu_op = ALU_NONE;
    shift  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL:           begin cls = CLS_R; alu_op = ALU_SLL; shift = 1'b1; end
          FN_SRL:           begin cls = CLS_R; alu_op = ALU_SRL; shift = 1'b1; end
          FN_ADD, FN_ADDU:  begin cls = CLS_R; alu_op = ALU_ADD; end
          FN_SUB, FN_SUBU:  begin cls = CLS_R; alu_op = ALU_SUB; end
          FN_AND:           begin cls = CLS_R; alu_op = ALU_AND; end
          FN_OR:            begin cls = CLS_R; alu_op = ALU_OR;  end
          FN_XOR:           begin cls = CLS_R; alu_op = ALU_XOR; end
          FN_SLT:           begin cls = CLS_R; alu_op = ALU_SLT; end
          FN_JR:            cls = CLS_JR;
`ifdef MC_MULT_EN
          FN_MULT, FN_MULTU: cls = CLS_MULT;
          FN_MFLO:           cls = CLS_MFLO;
`endif
          default: ;
        endcase
      end
      OP_ADDI:      begin cls = CLS_I; alu_op = ALU_ADD; end
      OP_SLTI:      begin cls = CLS_I; alu_op = ALU_SLT; end
      OP_ANDI:      begin cls = CLS_I; alu_op = ALU_AND; end
      OP_ORI:       begin cls = CLS_I; alu_op = ALU_OR;  end
      OP_XORI:      begin cls = CLS_I; alu_op = ALU_XOR; end
      OP_LB, OP_LW: begin cls = CLS_LOAD;  alu_op = ALU_ADD; end
      OP_SB, OP_SW: begin cls = CLS_STORE; alu_op = ALU_ADD; end
      OP_BEQ:       begin cls = CLS_BRANCH; alu_op = ALU_BEQ; end
      OP_BNE:       begin cls = CLS_BRANCH; alu_op = ALU_BNE; end
      OP_J:         cls = CLS_J;
      OP_JAL:       cls = CLS_JAL;
      default: ;
    endcase
  end

  assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM with memory wait/timeout handling and an
// illegal-instruction trap. MC_MULT_EN enables the multi-cycle multiply path.
module mc_control
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_TIMEOUT = 0,
  parameter int MULT_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  bcond,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  iord,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic                  reg_write,
  output logic [1:0]            reg_dest,
  output logic [1:0]            wb_sel,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic                  is_sll_srl,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  hilo_write,
  output logic                  instr_done,
  output logic                  trap,
  output logic                  trap_cause
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   mult_cnt_q, mult_cnt_d;
  logic               cause_q, cause_d;

  instr_class_e       cls;
  logic [3:0]         dec_alu;
  logic               dec_shift;
  logic               dec_illegal;
  logic               mem_state;
  logic               mem_timeout;
  logic               mult_last;
  logic [3:0]         alu_w;

  mc_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (cls),
    .alu_op  (dec_alu),
    .shift   (dec_shift),
    .illegal (dec_illegal)
  );

  // Wait counter only runs while a memory request is outstanding and unanswered,
  // so it is naturally zero on entry to every memory state.
  assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign mem_timeout = (MEM_TIMEOUT != 0) && !mem_ready &&
                       (wait_cnt_q == CNT_W'(MEM_TIMEOUT));
  assign mult_last   = (mult_cnt_q == CNT_W'(MULT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RESET;
      wait_cnt_q <= '0;
      mult_cnt_q <= '0;
      cause_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mult_cnt_q <= mult_cnt_d;
      cause_q    <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    wait_cnt_d = '0;
    mult_cnt_d = '0;
    if (mem_state && !mem_ready)
      wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
    if (state_q == S_MULT)
      mult_cnt_d = mult_cnt_q + 1'b1;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (mem_ready) begin
          state_d = (state_q == S_FETCH)  ? S_DECODE :
                    (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
        end else if (mem_timeout) begin
          state_d = S_TRAP;
          cause_d = 1'b1;
        end
      end
      S_DECODE: begin
        state_d = S_TRAP;
        cause_d = 1'b0;
        if (!dec_illegal) begin
          case (cls)
            CLS_R:              state_d = S_EXEC_R;
            CLS_I:              state_d = S_EXEC_I;
            CLS_LOAD, CLS_STORE: state_d = S_ADDR;
            CLS_BRANCH:         state_d = S_BRANCH;
            CLS_J, CLS_JAL:     state_d = S_JUMP;
            CLS_JR:             state_d = S_JR;
            CLS_MULT:           state_d = S_MULT;
            CLS_MFLO:           state_d = S_WB_ALU;
            default:            state_d = S_TRAP;
          endcase
        end
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_ADDR:   state_d = (cls == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_JR: state_d = S_FETCH;
      S_MULT:   if (mult_last) state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_RESET;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    reg_write  = 1'b0;
    reg_dest   = RD_RT;
    wb_sel     = WB_ALU_RES;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    is_sll_srl = 1'b0;
    alu_w      = ALU_ADD;
    hilo_write = 1'b0;
    instr_done = 1'b0;
    trap       = 1'b0;
    trap_cause = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH2;
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_w      = dec_alu;
        is_sll_srl = dec_shift;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_w     = dec_alu;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        alu_w   = ALU_NONE;
      end
      S_MEM_WR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        iord       = 1'b1;
        alu_w      = ALU_NONE;
        instr_done = mem_ready;
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        reg_dest   = (cls == CLS_I) ? RD_RT : RD_RD;
        wb_sel     = (cls == CLS_MFLO) ? WB_LO : WB_ALU_RES;
        alu_w      = ALU_NONE;
        instr_done = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        wb_sel     = WB_MEM_DATA;
        alu_w      = ALU_NONE;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_w      = dec_alu;
        pc_write   = bcond;
        pc_src     = PC_BRANCH;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PC_JUMP;
        alu_w      = ALU_NONE;
        instr_done = 1'b1;
        if (cls == CLS_JAL) begin
          reg_write = 1'b1;
          reg_dest  = RD_R31;
          wb_sel    = WB_PC;
        end
      end
      S_JR: begin
        pc_write   = 1'b1;
        pc_src     = PC_REG;
        alu_w      = ALU_NONE;
        instr_done = 1'b1;
      end
      S_MULT: begin
        alu_w      = ALU_NONE;
        instr_done = mult_last;
`ifdef MC_MULT_EN
        hilo_write = mult_last;
`endif
      end
      S_TRAP: begin
        trap       = 1'b1;
        trap_cause = cause_q;
      end
      default: ;
    endcase
    alu_control = ALU_CTRL_W'(alu_w);
  end

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control: an instruction-level model expands each
// instruction into its expected per-cycle output trace, compared every cycle.
module tb_mc_control;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_MULT    = 8;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_J = 5,
                 K_JAL = 6, K_JR = 7, K_MUL = 8, K_MFLO = 9, K_ILL = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       bcond = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write;
  logic [1:0] pc_src, reg_dest, wb_sel, alu_src_b;
  logic       alu_src_a, is_sll_srl, hilo_write, instr_done, trap, trap_cause;
  logic [3:0] alu_control;

  always #5 clk = ~clk;

  mc_control #(
    .ALU_CTRL_W  (4),
    .MEM_TIMEOUT (TB_TIMEOUT),
    .MULT_CYCLES (TB_MULT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .funct       (funct),
    .bcond       (bcond),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .iord        (iord),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .reg_dest    (reg_dest),
    .wb_sel      (wb_sel),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .is_sll_srl  (is_sll_srl),
    .alu_control (alu_control),
    .hilo_write  (hilo_write),
    .instr_done  (instr_done),
    .trap        (trap),
    .trap_cause  (trap_cause)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dest;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       is_sll_srl;
    logic [3:0] alu_control;
    logic       hilo_write;
    logic       instr_done;
    logic       trap;
    logic       trap_cause;
  } outs_t;

  outs_t      exp_q[$];
  bit         rst_q[$], rdy_q[$], bc_q[$], chk_q[$];
  logic [5:0] op_q[$], fn_q[$];
  string      tag_q[$];

  logic [5:0] t_op[$], t_fn[$];
  int         t_k[$];
  logic [3:0] t_alu[$];
  bit         t_sh[$];
  string      t_nm[$];

  logic [5:0] cur_op, cur_fn;
  string      cur_tag;
  int         checks = 0;
  int         failures = 0;

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int pick_delay();
    int x;
    x = $urandom_range(0, 19);
    if (x < 10) return 0;
    if (x < 18) return $urandom_range(1, TB_TIMEOUT);
    return TB_TIMEOUT + 1 + $urandom_range(0, 2);
  endfunction

  task automatic add_ins(input string nm, input logic [5:0] op, input logic [5:0] fn,
                         input int k, input logic [3:0] alu, input bit sh);
    t_nm.push_back(nm); t_op.push_back(op); t_fn.push_back(fn);
    t_k.push_back(k); t_alu.push_back(alu); t_sh.push_back(sh);
  endtask

  // Non-R-type instructions are identified by opcode alone.
  function automatic int find(input logic [5:0] op, input logic [5:0] fn);
    for (int i = 0; i < t_op.size(); i++)
      if (t_op[i] == op && (op != 6'd0 || t_fn[i] == fn)) return i;
    return -1;
  endfunction

  task automatic lit(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic push_raw(input outs_t e, input bit r, input bit rdy, input bit bc, input bit chk);
    exp_q.push_back(e); rst_q.push_back(r); rdy_q.push_back(rdy);
    bc_q.push_back(bc); chk_q.push_back(chk);
    op_q.push_back(cur_op); fn_q.push_back(cur_fn); tag_q.push_back(cur_tag);
  endtask

  task automatic push(input outs_t e, input bit rdy, input bit bc);
    push_raw(e, 1'b0, rdy, bc, 1'b1);
  endtask

  task automatic reset_seq();
    cur_tag = "reset";
    push_raw('0, 1'b1, rbit(), rbit(), 1'b0);
    push_raw('0, 1'b1, rbit(), rbit(), 1'b0);
    push('0, rbit(), rbit());
  endtask

  task automatic trap_seq(input bit cause);
    outs_t e;
    e = '0; e.trap = 1'b1; e.trap_cause = cause;
    for (int i = 0; i < 3; i++) push(e, rbit(), rbit());
    reset_seq();
  endtask

  // A request that is still unanswered on its TB_TIMEOUT-th counted cycle traps.
  task automatic mem_access(input outs_t ew, input outs_t ed, input int delay, output bit tmo);
    int n;
    tmo = (delay > TB_TIMEOUT);
    n = tmo ? TB_TIMEOUT + 1 : delay;
    for (int k = 0; k < n; k++) push(ew, 1'b0, rbit());
    if (!tmo) push(ed, 1'b1, rbit());
  endtask

  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input bit bcv,
                          input int fd, input int dd, output int ncyc);
    outs_t ew, ed, e;
    bit tmo;
    int idx, k, start;
    idx = find(op, fn);
    k = (idx < 0) ? K_ILL : t_k[idx];
    cur_op = op; cur_fn = fn;
    cur_tag = (idx < 0) ? "illegal" : t_nm[idx];
    start = exp_q.size();
    ncyc = -1;
    ew = '0; ew.mem_req = 1'b1; ew.alu_src_b = 2'd1;
    ed = ew; ed.ir_write = 1'b1; ed.pc_write = 1'b1;
    mem_access(ew, ed, fd, tmo);
    if (tmo) begin trap_seq(1'b1); return; end
    e = '0; e.alu_src_b = 2'd3;
    push(e, rbit(), rbit());
    e = '0;
    case (k)
      K_R, K_I: begin
        e.alu_src_a = 1'b1;
        e.alu_src_b = (k == K_I) ? 2'd2 : 2'd0;
        e.alu_control = t_alu[idx];
        e.is_sll_srl = t_sh[idx];
        push(e, rbit(), rbit());
        e = '0; e.reg_write = 1'b1; e.reg_dest = (k == K_I) ? 2'd0 : 2'd1;
        e.alu_control = 4'hf; e.instr_done = 1'b1;
        push(e, rbit(), rbit());
      end
      K_LD, K_ST: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
        push(e, rbit(), rbit());
        ew = '0; ew.mem_req = 1'b1; ew.iord = 1'b1; ew.alu_control = 4'hf;
        ew.mem_we = (k == K_ST);
        ed = ew; ed.instr_done = (k == K_ST);
        mem_access(ew, ed, dd, tmo);
        if (tmo) begin trap_seq(1'b1); return; end
        if (k == K_LD) begin
          e = '0; e.reg_write = 1'b1; e.wb_sel = 2'd1; e.alu_control = 4'hf;
          e.instr_done = 1'b1;
          push(e, rbit(), rbit());
        end
      end
      K_BR: begin
        e.alu_src_a = 1'b1; e.alu_control = t_alu[idx];
        e.pc_write = bcv; e.pc_src = 2'd1; e.instr_done = 1'b1;
        push(e, rbit(), bcv);
      end
      K_J, K_JAL, K_JR: begin
        e.pc_write = 1'b1; e.pc_src = (k == K_JR) ? 2'd3 : 2'd2;
        e.alu_control = 4'hf; e.instr_done = 1'b1;
        if (k == K_JAL) begin e.reg_write = 1'b1; e.reg_dest = 2'd2; e.wb_sel = 2'd2; end
        push(e, rbit(), rbit());
      end
      K_MUL: begin
        for (int c = 1; c <= TB_MULT; c++) begin
          e = '0; e.alu_control = 4'hf;
          e.hilo_write = (c == TB_MULT); e.instr_done = (c == TB_MULT);
          push(e, rbit(), rbit());
        end
      end
      K_MFLO: begin
        e.reg_write = 1'b1; e.reg_dest = 2'd1; e.wb_sel = 2'd3;
        e.alu_control = 4'hf; e.instr_done = 1'b1;
        push(e, rbit(), rbit());
      end
      default: begin trap_seq(1'b0); return; end
    endcase
    ncyc = exp_q.size() - start;
  endtask

  task automatic mid_fetch_reset();
    outs_t ew;
    cur_tag = "mid_reset";
    ew = '0; ew.mem_req = 1'b1; ew.alu_src_b = 2'd1;
    push(ew, 1'b0, rbit());
    push(ew, 1'b0, rbit());
    reset_seq();
  endtask

  initial begin
    int n, r, idx, cyc, act_done, exp_done;
    logic [5:0] op, fn;
    outs_t e, act;
    bit chk;

    add_ins("ADD", 6'b000000, 6'b100000, K_R, 4'd0, 0);
    add_ins("ADDU", 6'b000000, 6'b100001, K_R, 4'd0, 0);
    add_ins("SUB", 6'b000000, 6'b100010, K_R, 4'd6, 0);
    add_ins("SUBU", 6'b000000, 6'b100011, K_R, 4'd6, 0);
    add_ins("AND", 6'b000000, 6'b100100, K_R, 4'd1, 0);
    add_ins("OR", 6'b000000, 6'b100101, K_R, 4'd2, 0);
    add_ins("XOR", 6'b000000, 6'b100110, K_R, 4'd7, 0);
    add_ins("SLT", 6'b000000, 6'b101010, K_R, 4'd4, 0);
    add_ins("SLL", 6'b000000, 6'b000000, K_R, 4'd3, 1);
    add_ins("SRL", 6'b000000, 6'b000010, K_R, 4'd5, 1);
    add_ins("JR", 6'b000000, 6'b001000, K_JR, 4'd15, 0);
    add_ins("ADDI", 6'b001000, 6'd0, K_I, 4'd0, 0);
    add_ins("SLTI", 6'b001010, 6'd0, K_I, 4'd4, 0);
    add_ins("ANDI", 6'b001100, 6'd0, K_I, 4'd1, 0);
    add_ins("ORI", 6'b001101, 6'd0, K_I, 4'd2, 0);
    add_ins("XORI", 6'b001110, 6'd0, K_I, 4'd7, 0);
    add_ins("LW", 6'b100011, 6'd0, K_LD, 4'd0, 0);
    add_ins("LB", 6'b100000, 6'd0, K_LD, 4'd0, 0);
    add_ins("SW", 6'b101011, 6'd0, K_ST, 4'd0, 0);
    add_ins("SB", 6'b101000, 6'd0, K_ST, 4'd0, 0);
    add_ins("BEQ", 6'b000100, 6'd0, K_BR, 4'd8, 0);
    add_ins("BNE", 6'b000101, 6'd0, K_BR, 4'd9, 0);
    add_ins("J", 6'b000010, 6'd0, K_J, 4'd15, 0);
    add_ins("JAL", 6'b000011, 6'd0, K_JAL, 4'd15, 0);
`ifdef MC_MULT_EN
    add_ins("MULT", 6'b000000, 6'b011000, K_MUL, 4'd15, 0);
    add_ins("MULTU", 6'b000000, 6'b011001, K_MUL, 4'd15, 0);
    add_ins("MFLO", 6'b000000, 6'b010010, K_MFLO, 4'd15, 0);
`endif

    reset_seq();
    do_instr(6'b000000, 6'b100000, 0, 0, 0, n); lit("add_len", n, 4);
    do_instr(6'b100011, 6'd0, 0, 0, 3, n);      lit("lw_wait3_len", n, 8);
    do_instr(6'b101011, 6'd0, 0, 0, 0, n);      lit("sw_len", n, 4);
    do_instr(6'b000100, 6'd0, 0, 0, 0, n);      lit("beq_nt_len", n, 3);
    do_instr(6'b000100, 6'd0, 1, 0, 0, n);      lit("beq_t_len", n, 3);
    do_instr(6'b000011, 6'd0, 0, 0, 0, n);      lit("jal_len", n, 3);
    do_instr(6'b000000, 6'b001000, 0, 0, 0, n); lit("jr_len", n, 3);
    do_instr(6'b001000, 6'd0, 0, 2, 0, n);      lit("addi_fwait2_len", n, 6);
    do_instr(6'b100011, 6'd0, 0, 0, 4, n);      lit("lw_ready_at_limit_len", n, 9);
    do_instr(6'b100011, 6'd0, 0, 0, 5, n);      lit("lw_timeout", n, -1);
    do_instr(6'b000000, 6'b100000, 0, 6, 0, n); lit("fetch_timeout", n, -1);
    do_instr(6'b111111, 6'd0, 0, 0, 0, n);      lit("illegal_op", n, -1);
`ifdef MC_MULT_EN
    do_instr(6'b000000, 6'b011000, 0, 0, 0, n); lit("mult_len", n, 2 + TB_MULT);
    do_instr(6'b000000, 6'b010010, 0, 0, 0, n); lit("mflo_len", n, 3);
`else
    do_instr(6'b000000, 6'b011000, 0, 0, 0, n); lit("mult_illegal", n, -1);
`endif
    mid_fetch_reset();

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        mid_fetch_reset();
      end else if (r < 9) begin
        op = 6'h3f; fn = 6'h3f;
        for (int t = 0; t < 100; t++) begin
          op = 6'($urandom); fn = 6'($urandom);
          if (find(op, fn) < 0) break;
        end
        do_instr(op, fn, rbit(), pick_delay(), pick_delay(), n);
      end else begin
        idx = $urandom_range(0, t_op.size() - 1);
        do_instr(t_op[idx], t_fn[idx], rbit(), pick_delay(), pick_delay(), n);
      end
    end

    cyc = 0; act_done = 0; exp_done = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk = chk_q.pop_front();
      cur_tag = tag_q.pop_front();
      rst = rst_q.pop_front();
      mem_ready = rdy_q.pop_front();
      bcond = bc_q.pop_front();
      opcode = op_q.pop_front();
      funct = fn_q.pop_front();
      #1;
      if (chk) begin
        act.mem_req = mem_req; act.mem_we = mem_we; act.iord = iord;
        act.ir_write = ir_write; act.pc_write = pc_write; act.pc_src = pc_src;
        act.reg_write = reg_write; act.reg_dest = reg_dest; act.wb_sel = wb_sel;
        act.alu_src_a = alu_src_a; act.alu_src_b = alu_src_b;
        act.is_sll_srl = is_sll_srl; act.alu_control = alu_control;
        act.hilo_write = hilo_write; act.instr_done = instr_done;
        act.trap = trap; act.trap_cause = trap_cause;
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL outputs cyc=%0d instr=%s got=%h exp=%h", cyc, cur_tag, act, e);
        end
        if (instr_done === 1'b1) act_done++;
        exp_done += int'(e.instr_done);
      end
      cyc++;
    end
    lit("instr_done_count", act_done, exp_done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
